// File: rtl/neosd_dat_crc_pkg.sv
// neosd_pkg: shared SD DAT types and constants for the CRC engine and DAT FSM.
package neosd_pkg;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [2:0]  STATUS_OK  = 3'b010;

    typedef enum logic [3:0] {
        IDLE, DATA, CRC_TX, END_TX, STAT_WAIT, STAT_RX, CRC_RX, END_RX, DONE
    } crc_state_e;

    typedef enum logic {
        DM_READ  = 1'b0,
        DM_WRITE = 1'b1
    } data_mode_e;
endpackage

// File: rtl/neosd_dat_crc_crc16.sv
// neosd_crc16: registered CRC16-CCITT LFSR with clear, serial update and shift-out.
module neosd_crc16
    import neosd_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        shift_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);
    logic fb;
    assign fb = crc_o[15] ^ bit_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)      crc_o <= '0;
        else if (clr_i)   crc_o <= '0;
        else if (en_i)    crc_o <= {crc_o[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        else if (shift_i) crc_o <= {crc_o[14:0], 1'b0};
    end
endmodule

// File: rtl/neosd_dat_crc.sv
// neosd_dat_crc: serial CRC16 generate/check and write-status capture for one SD DAT line.
// NEOSD_DAT_CRC_TIMEOUT_EN adds a STAT_TIMEOUT-tick limit on waiting for the status start bit.
module neosd_dat_crc
    import neosd_pkg::*;
#(
    parameter int STAT_TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clkstrb_i,
    input  logic shift_i,
    input  logic start_i,
    input  logic dir_i,
    input  logic last_i,
    input  logic data_bit_i,
    input  logic sd_dat_i,
    output logic sd_dat_o,
    output logic sd_dat_oe_o,
    output logic sd_dat_sel_o,
    output logic busy_o,
    output logic done_o,
    output logic crc_err_o,
    output logic status_err_o
);
    crc_state_e  state, state_nxt;
    data_mode_e  mode;
    logic        tick, crc_clr, crc_en, crc_shift, tmo_hit;
    logic [3:0]  bit_cnt;
    logic [1:0]  stat_cnt;
    logic [1:0]  status;
    logic [15:0] crc, rx;

    assign tick = clkstrb_i && shift_i;

    neosd_crc16 u_crc (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clr_i   (crc_clr),
        .en_i    (crc_en),
        .shift_i (crc_shift),
        .bit_i   (data_bit_i),
        .crc_o   (crc)
    );

`ifdef NEOSD_DAT_CRC_TIMEOUT_EN
    localparam int TW = $clog2(STAT_TIMEOUT + 1);
    logic [TW-1:0] tmo;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                tmo <= '0;
        else if (state != STAT_WAIT) tmo <= '0;
        else if (tick)              tmo <= tmo + 1'b1;
    end

    assign tmo_hit = state == STAT_WAIT && tick && sd_dat_i && tmo == TW'(STAT_TIMEOUT - 1);
`else
    logic unused_tmo;
    assign unused_tmo = STAT_TIMEOUT != 0;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        crc_shift   = 1'b0;
        sd_dat_o    = 1'b0;
        sd_dat_oe_o = 1'b0;
        case (state)
            IDLE: if (clkstrb_i && start_i) begin
                state_nxt = DATA;
                crc_clr   = 1'b1;
            end
            DATA: if (tick) begin
                crc_en = 1'b1;
                if (last_i) state_nxt = mode == DM_WRITE ? CRC_TX : CRC_RX;
            end
            CRC_TX: begin
                sd_dat_o    = crc[15];
                sd_dat_oe_o = 1'b1;
                crc_shift   = tick;
                if (tick && bit_cnt == 4'd0) state_nxt = END_TX;
            end
            END_TX: begin
                sd_dat_o    = 1'b1;
                sd_dat_oe_o = 1'b1;
                if (tick) state_nxt = STAT_WAIT;
            end
            STAT_WAIT: state_nxt = (tick && !sd_dat_i) ? STAT_RX : tmo_hit ? DONE : STAT_WAIT;
            STAT_RX:   if (tick && stat_cnt == 2'd0) state_nxt = DONE;
            CRC_RX:    if (tick && bit_cnt == 4'd0) state_nxt = END_RX;
            END_RX:    if (tick) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    assign sd_dat_sel_o = sd_dat_oe_o;
    assign busy_o       = state != IDLE;
    assign done_o       = state == DONE;

    // Datapath registers; everything except the start capture advances only on a tick.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mode         <= DM_READ;
            bit_cnt      <= '0;
            stat_cnt     <= '0;
            status       <= '0;
            rx           <= '0;
            crc_err_o    <= 1'b0;
            status_err_o <= 1'b0;
        end else begin
            if (state == IDLE && clkstrb_i && start_i) begin
                mode         <= data_mode_e'(dir_i);
                crc_err_o    <= 1'b0;
                status_err_o <= 1'b0;
            end
            if (tmo_hit) status_err_o <= 1'b1;
            if (tick) begin
                if (state == DATA && last_i) bit_cnt <= 4'd15;
                if (state == CRC_TX || state == CRC_RX) bit_cnt <= bit_cnt - 1'b1;
                if (state == CRC_RX) rx <= {rx[14:0], sd_dat_i};
                if (state == STAT_WAIT && !sd_dat_i) stat_cnt <= 2'd2;
                if (state == STAT_RX) begin
                    status   <= {status[0], sd_dat_i};
                    stat_cnt <= stat_cnt - 1'b1;
                    if (stat_cnt == 2'd0) status_err_o <= {status, sd_dat_i} != STATUS_OK;
                end
                if (state == END_RX) crc_err_o <= rx != crc || !sd_dat_i;
            end
        end
    end
endmodule
